vote_tally_fsm: RTL and testbench
=================================

// Module: vote_tally_fsm
// PURPOSE
//  Per-candidate vote accumulator, directly downstream of the per-button
//  debounce/valid_vote stages. Takes one-cycle valid pulses from N_CAND
//  button controllers and accepts at most one vote per lockout window.
//  Rejects simultaneous presses as ambiguous and keeps saturating
//  per-candidate and total counts. In result mode it presents the selected
//  candidate's count for display.
// PARAMETERS
//  N_CAND      4    number of candidates (>=2)
//  CNT_W       8    per-candidate count width (saturating)
//  LOCK_CYCLES 16   cycles of vote lockout after an accepted vote (>=1)
// PORTS
//  clk        in   1                      system clock, rising edge
//  reset      in   1                      synchronous, active-high
//  mode       in   1                      0 = voting, 1 = result display
//  vote_valid in   N_CAND                 one-cycle pulses, bit i = candidate i
//  sel        in   clog2(N_CAND)          candidate shown in result mode
//  vote_ack   out  1                      one-cycle pulse: vote accepted
//  vote_led   out  1                      high while in LOCK
//  conflict   out  1                      one-cycle pulse: >1 vote bit set
//  busy       out  1                      high when state != IDLE
//  count_out  out  CNT_W                  count[sel] in RESULT, else 0
//  total_out  out  CNT_W+clog2(N_CAND)    saturating total of accepted votes
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high, and has priority over
//    everything. On reset: state=IDLE, all count[i]=0, total=0, lock timer=0,
//    and all outputs are 0 after that edge.
//  - States: IDLE, LOCK, RESULT. Every output is registered.
//  - IDLE, mode=1: go to RESULT next edge. Votes sampled in that cycle are
//    ignored.
//  - IDLE, mode=0, exactly one vote_valid bit i set at edge t:
//    * count[i] += 1, saturating at 2^CNT_W-1.
//    * total += 1, saturating at its own maximum.
//    * vote_ack=1 for the cycle after t.
//    * state=LOCK, with lock timer = LOCK_CYCLES-1.
//    * A vote on a saturated count still pulses vote_ack and still enters
//      LOCK.
//  - IDLE, mode=0, two or more bits set: no count change, conflict=1 for one
//    cycle, stay in IDLE.
//  - IDLE, mode=0, no bits set: hold.
//  - LOCK:
//    * vote_valid is ignored entirely; no conflict is flagged.
//    * vote_led=1 for exactly LOCK_CYCLES cycles.
//    * The timer decrements each cycle. At 0 the next state is RESULT if
//      mode=1, else IDLE.
//    * A mode change during LOCK takes effect only at LOCK exit.
//  - RESULT:
//    * count_out <= count[sel] every cycle (1-cycle latency from sel).
//    * vote_valid is ignored.
//    * mode=0 returns to IDLE next edge, with count_out=0 from that edge.
//    * sel >= N_CAND gives count_out=0.
//  - total_out is always valid (all states). Counts persist across mode
//    changes and clear only on reset.
//  - Earliest second accepted vote: LOCK_CYCLES+1 cycles after the first.
// TESTING
//  1. reset; mode=0; vote_valid=4'b0010 for 1 cycle -> next cycle vote_ack=1,
//     count[1]=1, total_out=1, vote_led high for 16 cycles, then busy=0.
//  2. During LOCK, pulse bit0 at lock cycle 5 -> ignored (count[0]=0). Pulse
//     bit0 after LOCK -> count[0]=1, total_out=2.
//  3. In IDLE, vote_valid=4'b0101 -> conflict=1 for 1 cycle, no vote_ack,
//     counts and total unchanged, state stays IDLE.
//  4. 300 accepted votes on candidate 2 (CNT_W=8) -> count[2]=255 (saturated),
//     total_out=300, vote_ack pulses 300 times.
//  5. mode=1, sel=2 -> count_out=255 one cycle after RESULT entry. Votes
//     during RESULT are ignored. mode=0 -> count_out=0 and state IDLE next
//     edge.
//  6. Assert reset during LOCK (cycle 8) -> next edge all counts, total and
//     outputs are 0 and state is IDLE. A vote right after reset release is
//     accepted immediately.

Source files
------------

// File: rtl/vote_tally_fsm.sv
// Vote tally: accepts at most one unambiguous vote per lockout window into
// saturating per-candidate and total counters; RESULT state shows count[sel].
module vote_tally_fsm #(
  parameter int N_CAND      = 4,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 16,
  localparam int SEL_W      = $clog2(N_CAND),
  localparam int TOT_W      = CNT_W + SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [N_CAND-1:0] vote_valid,
  input  logic [SEL_W-1:0]  sel,
  output logic              vote_ack,
  output logic              vote_led,
  output logic              conflict,
  output logic              busy,
  output logic [CNT_W-1:0]  count_out,
  output logic [TOT_W-1:0]  total_out
);

  localparam int TMR_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [TMR_W-1:0]   timer_r, timer_nxt_s;
  logic [CNT_W-1:0]   count_r [N_CAND];
  logic [TOT_W-1:0]   total_r;
  logic               ack_r, conflict_r, led_r, busy_r;
  logic [CNT_W-1:0]   count_out_r;

  logic               ack_nxt_s, conflict_nxt_s, accept_s;
  logic               vote_single_s, vote_multi_s;
  logic [CNT_W-1:0]   sel_cnt_s, count_out_nxt_s;

  // Classify the vote vector and select the displayed count
  always_comb begin
    vote_multi_s  = |(vote_valid & (vote_valid - N_CAND'(1)));
    vote_single_s = (|vote_valid) & ~vote_multi_s;
    sel_cnt_s     = '0;
    // Out-of-range sel matches no candidate and leaves the count at zero
    for (int i = 0; i < N_CAND; i++) begin
      sel_cnt_s = (sel == SEL_W'(i)) ? count_r[i] : sel_cnt_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s     = state_r;
    timer_nxt_s     = timer_r;
    ack_nxt_s       = 1'b0;
    conflict_nxt_s  = 1'b0;
    accept_s        = 1'b0;
    count_out_nxt_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (mode) begin
          state_nxt_s = ST_RESULT;
        end else if (vote_single_s) begin
          accept_s    = 1'b1;
          ack_nxt_s   = 1'b1;
          state_nxt_s = ST_LOCK;
          timer_nxt_s = TMR_LOAD;
        end else if (vote_multi_s) begin
          conflict_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCK: begin
        // mode is only consulted on the final lockout cycle
        if (timer_r == '0) begin
          if (mode) begin
            state_nxt_s = ST_RESULT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end
      end
      ST_RESULT: begin
        if (mode) begin
          count_out_nxt_s = sel_cnt_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        timer_nxt_s = '0;
      end
    endcase
  end

  // State, timer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      ack_r       <= 1'b0;
      conflict_r  <= 1'b0;
      led_r       <= 1'b0;
      busy_r      <= 1'b0;
      count_out_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      ack_r       <= ack_nxt_s;
      conflict_r  <= conflict_nxt_s;
      led_r       <= (state_nxt_s == ST_LOCK);
      busy_r      <= (state_nxt_s != ST_IDLE);
      count_out_r <= count_out_nxt_s;
    end
  end

  // Saturating per-candidate and total counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CAND; i++) begin
        count_r[i] <= '0;
      end
      total_r <= '0;
    end else if (accept_s) begin
      for (int i = 0; i < N_CAND; i++) begin
        if (vote_valid[i] && (count_r[i] != CNT_MAX)) begin
          count_r[i] <= count_r[i] + CNT_W'(1);
        end
      end
      if (total_r != TOT_MAX) begin
        total_r <= total_r + TOT_W'(1);
      end
    end
  end

  assign vote_ack  = ack_r;
  assign conflict  = conflict_r;
  assign vote_led  = led_r;
  assign busy      = busy_r;
  assign count_out = count_out_r;
  assign total_out = total_r;

endmodule

// File: tb/tb_vote_tally_fsm.sv
// Bench for vote_tally_fsm: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the voting rules.
module tb_vote_tally_fsm;
  localparam int N_CAND = 4;
  localparam int CNT_W = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int CNT_MAX = 255;
  localparam int TOT_MAX = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic [3:0] vote_valid = 4'b0000;
  logic [1:0] sel = 2'd0;
  logic       vote_ack, vote_led, conflict, busy;
  logic [7:0] count_out;
  logic [9:0] total_out;

  int vectors = 0;
  int miscompares = 0;

  // Model: remaining lockout cycles, result-mode flag, plain integer counts
  int m_cnt [N_CAND];
  int m_total = 0;
  int m_lock_left = 0;
  bit m_result = 1'b0;
  bit e_ack = 1'b0, e_conflict = 1'b0, e_led = 1'b0, e_busy = 1'b0;
  int e_count_out = 0;

  vote_tally_fsm #(.N_CAND(N_CAND), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk(clk), .reset(reset), .mode(mode), .vote_valid(vote_valid), .sel(sel),
    .vote_ack(vote_ack), .vote_led(vote_led), .conflict(conflict), .busy(busy),
    .count_out(count_out), .total_out(total_out)
  );

  always #5 clk = ~clk;

  task automatic step(input bit rst, input bit md, input logic [3:0] vv, input logic [1:0] s);
    reset = rst; mode = md; vote_valid = vv; sel = s;
    @(posedge clk);
    #1;
    e_ack = 1'b0; e_conflict = 1'b0; e_count_out = 0;
    if (rst) begin
      for (int i = 0; i < N_CAND; i++) m_cnt[i] = 0;
      m_total = 0; m_lock_left = 0; m_result = 1'b0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_result = md;
    end else if (m_result) begin
      if (md) e_count_out = (int'(s) < N_CAND) ? m_cnt[s] : 0;
      else m_result = 1'b0;
    end else if (md) begin
      m_result = 1'b1;
    end else if ($countones(vv) == 1) begin
      for (int i = 0; i < N_CAND; i++)
        if (vv[i]) m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
      m_total = (m_total < TOT_MAX) ? m_total + 1 : TOT_MAX;
      e_ack = 1'b1;
      m_lock_left = LOCK_CYCLES;
    end else if ($countones(vv) > 1) begin
      e_conflict = 1'b1;
    end
    e_led = (m_lock_left > 0);
    e_busy = (m_lock_left > 0) || m_result;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'b0000, 2'd0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 4'b0000, 2'd0);
    vectors += 6;
    if (vote_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", vote_ack); end
    if (conflict !== 1'b0) begin miscompares++; $display("FAIL reset_conflict got %b want 0", conflict); end
    if (vote_led !== 1'b0) begin miscompares++; $display("FAIL reset_led got %b want 0", vote_led); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    if (count_out !== 8'd0) begin miscompares++; $display("FAIL reset_count_out got %0d want 0", count_out); end
    if (total_out !== 10'd0) begin miscompares++; $display("FAIL reset_total got %0d want 0", total_out); end
  endtask

  task automatic test_single_vote();
    step(1'b0, 1'b0, 4'b0010, 2'd0);
    vectors += 3;
    if (vote_ack !== 1'b1) begin miscompares++; $display("FAIL sv_ack got %b want 1", vote_ack); end
    if (total_out !== 10'd1) begin miscompares++; $display("FAIL sv_total got %0d want 1", total_out); end
    if (vote_led !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL sv_lock_entry led %b busy %b want 1 1", vote_led, busy); end
    for (int k = 1; k < LOCK_CYCLES; k++) begin
      step(1'b0, 1'b0, 4'b0000, 2'd0);
      vectors++;
      if (vote_led !== 1'b1 || vote_ack !== 1'b0) begin
        miscompares++; $display("FAIL sv_lock_hold cycle %0d led %b ack %b want 1 0", k, vote_led, vote_ack);
      end
    end
    step(1'b0, 1'b0, 4'b0000, 2'd0);
    vectors++;
    if (vote_led !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL sv_lock_exit led %b busy %b want 0 0", vote_led, busy); end
  endtask

  task automatic test_lock_ignore();
    step(1'b0, 1'b0, 4'b0010, 2'd0);
    for (int k = 1; k < LOCK_CYCLES; k++) begin
      step(1'b0, 1'b0, (k == 5) ? 4'b0001 : 4'b0000, 2'd0);
      if (k == 5) begin
        vectors++;
        if (vote_ack !== 1'b0 || conflict !== 1'b0 || total_out !== 10'd2) begin
          miscompares++; $display("FAIL li_in_lock ack %b conflict %b total %0d want 0 0 2", vote_ack, conflict, total_out);
        end
      end
    end
    step(1'b0, 1'b0, 4'b0001, 2'd0);
    vectors++;
    if (vote_ack !== 1'b0 || total_out !== 10'd2) begin miscompares++; $display("FAIL li_exit_edge ack %b total %0d want 0 2", vote_ack, total_out); end
    step(1'b0, 1'b0, 4'b0001, 2'd0);
    vectors++;
    if (vote_ack !== 1'b1 || total_out !== 10'd3) begin miscompares++; $display("FAIL li_after_lock ack %b total %0d want 1 3", vote_ack, total_out); end
    idle(LOCK_CYCLES);
    step(1'b0, 1'b1, 4'b0000, 2'd0);
    step(1'b0, 1'b1, 4'b0000, 2'd0);
    vectors++;
    if (count_out !== 8'd1) begin miscompares++; $display("FAIL li_count0 got %0d want 1", count_out); end
    step(1'b0, 1'b0, 4'b0000, 2'd0);
  endtask

  task automatic test_conflict();
    step(1'b0, 1'b0, 4'b0101, 2'd0);
    vectors += 2;
    if (conflict !== 1'b1 || vote_ack !== 1'b0) begin miscompares++; $display("FAIL cf_pulse conflict %b ack %b want 1 0", conflict, vote_ack); end
    if (total_out !== 10'd3 || busy !== 1'b0) begin miscompares++; $display("FAIL cf_state total %0d busy %b want 3 0", total_out, busy); end
    step(1'b0, 1'b0, 4'b0000, 2'd0);
    vectors++;
    if (conflict !== 1'b0) begin miscompares++; $display("FAIL cf_one_cycle got %b want 0", conflict); end
  endtask

  task automatic test_saturation();
    int acks;
    acks = 0;
    step(1'b1, 1'b0, 4'b0000, 2'd0);
    for (int n = 0; n < 300; n++) begin
      step(1'b0, 1'b0, 4'b0100, 2'd0);
      if (vote_ack === 1'b1) acks++;
      idle(LOCK_CYCLES);
    end
    vectors += 2;
    if (acks !== 300) begin miscompares++; $display("FAIL sat_acks got %0d want 300", acks); end
    if (total_out !== 10'd300) begin miscompares++; $display("FAIL sat_total got %0d want 300", total_out); end
  endtask

  task automatic test_result();
    step(1'b0, 1'b1, 4'b0000, 2'd2);
    vectors++;
    if (busy !== 1'b1 || count_out !== 8'd0) begin miscompares++; $display("FAIL rs_entry busy %b count %0d want 1 0", busy, count_out); end
    step(1'b0, 1'b1, 4'b0000, 2'd2);
    vectors++;
    if (count_out !== 8'd255) begin miscompares++; $display("FAIL rs_count2 got %0d want 255", count_out); end
    step(1'b0, 1'b1, 4'b0001, 2'd2);
    vectors++;
    if (vote_ack !== 1'b0 || total_out !== 10'd300 || vote_led !== 1'b0) begin
      miscompares++; $display("FAIL rs_vote_ignored ack %b total %0d led %b want 0 300 0", vote_ack, total_out, vote_led);
    end
    step(1'b0, 1'b1, 4'b0000, 2'd1);
    vectors++;
    if (count_out !== 8'd0) begin miscompares++; $display("FAIL rs_sel1 got %0d want 0", count_out); end
    step(1'b0, 1'b0, 4'b0000, 2'd2);
    vectors++;
    if (count_out !== 8'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL rs_exit count %0d busy %b want 0 0", count_out, busy); end
  endtask

  task automatic test_reset_in_lock();
    step(1'b0, 1'b0, 4'b1000, 2'd0);
    idle(7);
    step(1'b1, 1'b0, 4'b0000, 2'd0);
    vectors += 2;
    if (total_out !== 10'd0 || vote_led !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rl_cleared total %0d led %b busy %b want 0 0 0", total_out, vote_led, busy);
    end
    if (vote_ack !== 1'b0 || conflict !== 1'b0 || count_out !== 8'd0) begin
      miscompares++; $display("FAIL rl_outputs ack %b conflict %b count %0d want 0 0 0", vote_ack, conflict, count_out);
    end
    step(1'b0, 1'b0, 4'b1000, 2'd0);
    vectors++;
    if (vote_ack !== 1'b1 || total_out !== 10'd1) begin miscompares++; $display("FAIL rl_first_vote ack %b total %0d want 1 1", vote_ack, total_out); end
    idle(LOCK_CYCLES);
    step(1'b0, 1'b1, 4'b0000, 2'd2);
    step(1'b0, 1'b1, 4'b0000, 2'd2);
    vectors++;
    if (count_out !== 8'd0) begin miscompares++; $display("FAIL rl_count2 got %0d want 0", count_out); end
    step(1'b0, 1'b1, 4'b0000, 2'd3);
    vectors++;
    if (count_out !== 8'd1) begin miscompares++; $display("FAIL rl_count3 got %0d want 1", count_out); end
    step(1'b0, 1'b0, 4'b0000, 2'd0);
  endtask

  task automatic test_total_saturation();
    logic [3:0] vv;
    step(1'b1, 1'b0, 4'b0000, 2'd0);
    for (int n = 0; n < 1030; n++) begin
      vv = 4'b0001 << (n % 4);
      step(1'b0, 1'b0, vv, 2'd0);
      idle(LOCK_CYCLES);
    end
    vectors++;
    if (total_out !== 10'd1023) begin miscompares++; $display("FAIL ts_total got %0d want 1023", total_out); end
    step(1'b0, 1'b1, 4'b0000, 2'd0);
    step(1'b0, 1'b1, 4'b0000, 2'd0);
    vectors++;
    if (count_out !== 8'd255) begin miscompares++; $display("FAIL ts_count0 got %0d want 255", count_out); end
    step(1'b0, 1'b0, 4'b0000, 2'd0);
  endtask

  task automatic test_random();
    bit md;
    bit rst;
    logic [3:0] vv;
    int r;
    md = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) md = ~md;
      rst = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      if (r < 6) vv = 4'b0000;
      else if (r < 9) vv = 4'b0001 << $urandom_range(0, 3);
      else vv = 4'($urandom);
      step(rst, md, vv, 2'($urandom));
      vectors += 6;
      if (vote_ack !== e_ack) begin miscompares++; $display("FAIL rnd_ack cycle %0d got %b want %b", c, vote_ack, e_ack); end
      if (conflict !== e_conflict) begin miscompares++; $display("FAIL rnd_conflict cycle %0d got %b want %b", c, conflict, e_conflict); end
      if (vote_led !== e_led) begin miscompares++; $display("FAIL rnd_led cycle %0d got %b want %b", c, vote_led, e_led); end
      if (busy !== e_busy) begin miscompares++; $display("FAIL rnd_busy cycle %0d got %b want %b", c, busy, e_busy); end
      if (int'(count_out) !== e_count_out) begin miscompares++; $display("FAIL rnd_count_out cycle %0d got %0d want %0d", c, count_out, e_count_out); end
      if (int'(total_out) !== m_total) begin miscompares++; $display("FAIL rnd_total cycle %0d got %0d want %0d", c, total_out, m_total); end
    end
  endtask

  initial begin
    for (int i = 0; i < N_CAND; i++) m_cnt[i] = 0;
    test_reset();
    test_single_vote();
    test_lock_ignore();
    test_conflict();
    test_saturation();
    test_result();
    test_reset_in_lock();
    test_total_saturation();
    step(1'b1, 1'b0, 4'b0000, 2'd0);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
